ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_manager_pack.sv | 46 ++++
 rtl/ahb_rr_pick.sv | 29 ++
 rtl/ahb_arbiter.sv | 86 ++++++++
 tb/tb_ahb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_manager_pack.sv
// ahb_manager_pack: shared AHB transfer types plus the arbiter state encoding and helpers.
package ahb_manager_pack;

  typedef enum logic [1:0] {
    HTRANS_IDLE,
    HTRANS_BUSY,
    HTRANS_NONSEQ,
    HTRANS_SEQ
  } t_htrans;

  typedef enum logic [2:0] {
    HBURST_SINGLE,
    HBURST_INCR,
    HBURST_WRAP4,
    HBURST_INCR4,
    HBURST_WRAP8,
    HBURST_INCR8,
    HBURST_WRAP16,
    HBURST_INCR16
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY,
    HRESP_ERROR,
    HRESP_RETRY,
    HRESP_SPLIT
  } t_hresp;

  typedef enum logic {
    ARB,
    LOCK
  } t_arb_state;

  // SEQ beats still owed after the NONSEQ of a lockable burst; zero means never lock.
  function automatic logic [4:0] burst_len(input t_hburst b);
    return b == HBURST_INCR4 ? 5'd3 : b == HBURST_INCR8 ? 5'd7 : b == HBURST_INCR16 ? 5'd15 : 5'd0;
  endfunction

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = oh[i] ? r | 4'(i) : r;
    return r;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational round-robin pick, searching from (i_ptr + 1) mod N.
module ahb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic                 o_valid
);
  localparam int W = $clog2(N);

  logic [W-1:0] idx;
  int k;

  // Walk from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    o_gnt = '0;
    idx = '0;
    k = 0;
    for (int i = N; i >= 1; i--) begin
      k = int'(i_ptr) + i;
      idx = W'(k >= N ? k - N : k);
      o_gnt = i_req[idx] ? N'(1) << idx : o_gnt;
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with fixed-length burst locking and SPLIT masking.
module ahb_arbiter
  import ahb_manager_pack::*;
#(
  parameter int NUM_MGR = 4,
  parameter int DEF_MGR = 0
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset_n,
  input  logic [NUM_MGR-1:0]         i_hbusreq,
  input  t_htrans                    i_htrans,
  input  t_hburst                    i_hburst,
  input  logic                       i_hready,
  input  t_hresp                     i_hresp,
  input  logic [NUM_MGR-1:0]         i_hsplit,
  output logic [NUM_MGR-1:0]         o_hgrant,
  output logic [$clog2(NUM_MGR)-1:0] o_hmaster,
  output logic [$clog2(NUM_MGR)-1:0] o_hmaster_d
);
  localparam int W = $clog2(NUM_MGR);
  localparam logic [W-1:0] DEF_IDX = W'(DEF_MGR);
  localparam logic [NUM_MGR-1:0] DEF_OH = NUM_MGR'(1) << DEF_MGR;

  t_arb_state state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [NUM_MGR-1:0] mask_q, mask_d, grant_q, grant_d, pick_gnt;
  logic [W-1:0] ptr_q, ptr_d, owner_q, owner_d, downer_q, downer_d, pick_idx;
  logic pick_vld, start_lock, hold, rearb;

  ahb_rr_pick #(.N(NUM_MGR)) u_pick (
    .i_req  (i_hbusreq & ~mask_q),
    .i_ptr  (ptr_q),
    .o_gnt  (pick_gnt),
    .o_valid(pick_vld)
  );

  assign pick_idx = W'(oh2idx(16'(pick_gnt)));

  always_comb begin
    start_lock = i_htrans == HTRANS_NONSEQ && burst_len(i_hburst) != 5'd0;
    hold = state_q == LOCK && (i_htrans == HTRANS_BUSY || (i_htrans == HTRANS_SEQ && cnt_q != 5'd1));
    rearb = i_hready && !start_lock && !hold;
    state_d = state_q;
    cnt_d = cnt_q;
    mask_d = mask_q & ~i_hsplit;
    if (!i_hready && i_hresp != HRESP_OKAY) begin
      state_d = ARB;
      cnt_d = '0;
    end
    // Applied after the split-resume clear so a same-edge set takes priority.
    if (!i_hready && i_hresp == HRESP_SPLIT) mask_d[downer_q] = 1'b1;
    if (i_hready) begin
      state_d = (start_lock || hold) ? LOCK : ARB;
      cnt_d = start_lock ? burst_len(i_hburst) : hold && i_htrans == HTRANS_SEQ ? cnt_q - 5'd1 : hold ? cnt_q : 5'd0;
    end
    downer_d = i_hready ? owner_q : downer_q;
    grant_d = rearb ? (pick_vld ? pick_gnt : DEF_OH) : grant_q;
    owner_d = rearb ? (pick_vld ? pick_idx : DEF_IDX) : owner_q;
    ptr_d = rearb && pick_vld && pick_idx != owner_q ? pick_idx : ptr_q;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ARB;
      cnt_q <= '0;
      mask_q <= '0;
      ptr_q <= DEF_IDX;
      grant_q <= DEF_OH;
      owner_q <= DEF_IDX;
      downer_q <= DEF_IDX;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      downer_q <= downer_d;
    end
  end

  assign o_hgrant = grant_q;
  assign o_hmaster = owner_q;
  assign o_hmaster_d = downer_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios with literal expectations plus a per-cycle check against a bus-ownership model.
module tb_ahb_arbiter;
  import ahb_manager_pack::*;

  localparam int N = 4;
  localparam int DEF = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] hbusreq = '0;
  logic [N-1:0] hsplit = '0;
  t_htrans htrans = HTRANS_IDLE;
  t_hburst hburst = HBURST_SINGLE;
  logic hready = 1'b1;
  t_hresp hresp = HRESP_OKAY;
  logic [N-1:0] hgrant;
  logic [1:0] hmaster, hmaster_d;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int owner;
    int downer;
    int last;
    bit locked;
    int left;
    logic [N-1:0] mask;
  } mstate_t;

  mstate_t m;

  ahb_arbiter #(.NUM_MGR(N), .DEF_MGR(DEF)) dut (
    .i_hclk     (clk),
    .i_hreset_n (rst_n),
    .i_hbusreq  (hbusreq),
    .i_htrans   (htrans),
    .i_hburst   (hburst),
    .i_hready   (hready),
    .i_hresp    (hresp),
    .i_hsplit   (hsplit),
    .o_hgrant   (hgrant),
    .o_hmaster  (hmaster),
    .o_hmaster_d(hmaster_d)
  );

  always #5 clk = ~clk;

  function automatic int burst_beats(input t_hburst b);
    return b == HBURST_INCR4 ? 4 : b == HBURST_INCR8 ? 8 : b == HBURST_INCR16 ? 16 : 0;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r.owner = DEF;
    r.downer = DEF;
    r.last = DEF;
    r.locked = 1'b0;
    r.left = 0;
    r.mask = '0;
    return r;
  endfunction

  // Ownership rules: a lockable burst keeps the bus until its last SEQ is accepted,
  // otherwise every ready edge hands the next address phase to the next unmasked requester.
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    int c;
    bit found;
    n = s;
    found = 1'b0;
    n.mask = s.mask & ~hsplit;
    if (!hready) begin
      if (hresp != HRESP_OKAY) begin
        n.locked = 1'b0;
        n.left = 0;
      end
      if (hresp == HRESP_SPLIT) n.mask[s.downer] = 1'b1;
    end else begin
      n.downer = s.owner;
      if (htrans == HTRANS_NONSEQ && burst_beats(hburst) > 0) begin
        n.locked = 1'b1;
        n.left = burst_beats(hburst) - 1;
      end else if (s.locked && htrans == HTRANS_BUSY) begin
        n.left = s.left;
      end else if (s.locked && htrans == HTRANS_SEQ && s.left > 1) begin
        n.left = s.left - 1;
      end else begin
        n.locked = 1'b0;
        n.left = 0;
        n.owner = DEF;
        for (int k = N; k >= 1; k--) begin
          c = (s.last + k) % N;
          if (hbusreq[c] && !s.mask[c]) begin
            n.owner = c;
            found = 1'b1;
          end
        end
        if (found && n.owner != s.owner) n.last = n.owner;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= model_reset();
    else m <= model_next(m);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("model_grant", 32'(hgrant), 32'(1) << m.owner);
      chk("model_hmaster", 32'(hmaster), 32'(m.owner));
      chk("model_hmaster_d", 32'(hmaster_d), 32'(m.downer));
      chk("grant_onehot", 32'($onehot(hgrant)), 32'd1);
    end

  task automatic cyc(input logic [N-1:0] req, input t_htrans tr, input t_hburst hb,
                     input logic rdy = 1'b1, input t_hresp rs = HRESP_OKAY, input logic [N-1:0] sp = '0);
    hbusreq = req;
    htrans = tr;
    hburst = hb;
    hready = rdy;
    hresp = rs;
    hsplit = sp;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(hgrant), 32'b0001);
    chk("rst_hmaster", 32'(hmaster), 32'd0);
    chk("rst_hmaster_d", 32'(hmaster_d), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(4'b0000, HTRANS_IDLE, HBURST_SINGLE);
    chk("idle_default", 32'(hgrant), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0110, HTRANS_NONSEQ, HBURST_SINGLE);
      chk("rr_alternate", 32'(hgrant), (i % 2) != 0 ? 32'b0100 : 32'b0010);
    end
    chk("rr_hmaster_d", 32'(hmaster_d), 32'd1);
    cyc(4'b1100, HTRANS_NONSEQ, HBURST_INCR8);
    chk("incr8_lock", 32'(hgrant), 32'b0100);
    repeat (2) cyc(4'b1100, HTRANS_SEQ, HBURST_INCR8);
    cyc(4'b1100, HTRANS_BUSY, HBURST_INCR8);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1100, HTRANS_SEQ, HBURST_INCR8);
      chk("incr8_hold", 32'(hgrant), 32'b0100);
    end
    cyc(4'b1100, HTRANS_SEQ, HBURST_INCR8);
    chk("incr8_release", 32'(hgrant), 32'b1000);
    repeat (2) cyc(4'b0010, HTRANS_NONSEQ, HBURST_SINGLE);
    chk("split_owner", 32'(hmaster_d), 32'd1);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_SPLIT);
    chk("split_wait_hold", 32'(hgrant), 32'b0010);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_SPLIT);
    chk("split_masked", 32'(hgrant), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE);
      chk("split_still_masked", 32'(hgrant), 32'b0001);
    end
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010);
    chk("split_resume_edge", 32'(hgrant), 32'b0001);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE);
    chk("split_resume", 32'(hgrant), 32'b0010);
    cyc(4'b0010, HTRANS_NONSEQ, HBURST_SINGLE);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_SPLIT, 4'b0010);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE);
    chk("split_set_wins", 32'(hgrant), 32'b0001);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010);
    cyc(4'b0010, HTRANS_IDLE, HBURST_SINGLE);
    chk("split_set_wins_resume", 32'(hgrant), 32'b0010);
    cyc(4'b0110, HTRANS_NONSEQ, HBURST_INCR4);
    chk("incr4_lock", 32'(hgrant), 32'b0010);
    cyc(4'b0110, HTRANS_SEQ, HBURST_INCR4, 1'b0, HRESP_RETRY);
    chk("retry_wait_hold", 32'(hgrant), 32'b0010);
    cyc(4'b0110, HTRANS_BUSY, HBURST_INCR4);
    chk("retry_unlock", 32'(hgrant), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      chk("stall_hold", 32'(hgrant), 32'b0100);
    end
    cyc(4'b1000, HTRANS_IDLE, HBURST_SINGLE);
    chk("stall_release", 32'(hgrant), 32'b1000);
    cyc(4'b1000, HTRANS_NONSEQ, HBURST_INCR16);
    repeat (4) cyc(4'b1000, HTRANS_SEQ, HBURST_INCR16);
    chk("incr16_hold", 32'(hgrant), 32'b1000);
    htrans = HTRANS_SEQ;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(hgrant), 32'b0001);
    chk("async_rst_hmaster", 32'(hmaster), 32'd0);
    chk("async_rst_hmaster_d", 32'(hmaster_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0100, HTRANS_SEQ, HBURST_INCR16);
    chk("post_reset_arb", 32'(hgrant), 32'b0100);
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      rdy = $urandom_range(0, 3) != 0;
      cyc(N'($urandom), t_htrans'($urandom_range(0, 3)), t_hburst'($urandom_range(0, 7)), rdy,
          rdy ? HRESP_OKAY : t_hresp'($urandom_range(0, 3)), $urandom_range(0, 5) == 0 ? N'($urandom) : '0);
    end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
